// File: rtl/counter_sequencer.sv
// ---------------------------------------------------------------------------
// counter_sequencer
//
// Upstream controller for the counter block. It accepts run commands over a
// valid/ready handshake and then drives the counter's clr/inc/max_val inputs
// while it watches the counter's eq flag. It produces prescaled increment
// ticks and repeats whole count periods a set number of times, or forever.
// It reports each period end and each finished command to the surrounding
// control logic.
//
// Parameters
//   WIDTH  count width; must match the counter being driven
//   PRE_W  prescaler width; a tick occurs every (pre+1) clk cycles
//   REP_W  repeat-count width; a repeat count of 0 means run until abort
//
// Ports
//   clk          in   1      clock, all logic on posedge
//   rst          in   1      synchronous reset, active-high
//   cmd_valid    in   1      command present
//   cmd_ready    out  1      command accepted when cmd_valid & cmd_ready
//   cmd_max      in   WIDTH  terminal count for the run
//   cmd_pre      in   PRE_W  prescale value (tick period = cmd_pre+1 cycles)
//   cmd_reps     in   REP_W  number of periods, 0 = infinite
//   abort        in   1      stop the current run
//   cnt_clr      out  1      to counter clr
//   cnt_inc      out  1      to counter inc
//   cnt_max_val  out  WIDTH  to counter max_val (registered)
//   cnt_eq       in   1      from counter eq
//   period_pulse out  1      one-cycle pulse at each period end
//   done         out  1      one-cycle pulse when a finite run completes
//   busy         out  1      high whenever a command is being executed
//   reps_left    out  REP_W  remaining periods (registered)
// ---------------------------------------------------------------------------
module counter_sequencer #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_max,
    input  logic [PRE_W-1:0] cmd_pre,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             abort,
    output logic             cnt_clr,
    output logic             cnt_inc,
    output logic [WIDTH-1:0] cnt_max_val,
    input  logic             cnt_eq,
    output logic             period_pulse,
    output logic             done,
    output logic             busy,
    output logic [REP_W-1:0] reps_left
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PRE_W-1:0]   prescaler;
    logic [PRE_W-1:0]   pre_reg;
    logic               tick;
    logic               period_end;

    // A tick is the last cycle of each prescale interval. A period ends on a
    // tick where the counter already sits at its terminal count. An abort
    // takes priority, so it suppresses the period end in that same cycle.
    assign tick       = (state == S_RUN) && (prescaler == pre_reg);
    assign period_end = tick && cnt_eq && !abort;

    // Next-state and counter-control decode. Reset forces the counter clear
    // and gates every other output low, because the state register still
    // holds its pre-reset value until the clock edge.
    always_comb begin
        state_next   = state;
        cmd_ready    = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        period_pulse = 1'b0;
        done         = 1'b0;
        busy         = 1'b0;

        if (rst) begin
            cnt_clr = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        state_next = S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    busy    = 1'b1;
                    cnt_clr = 1'b1;
                    state_next = abort ? S_IDLE : S_RUN;
                end

                S_RUN: begin
                    busy = 1'b1;
                    if (abort) begin
                        cnt_clr    = 1'b1;
                        state_next = S_IDLE;
                    end else if (tick) begin
                        if (cnt_eq) begin
                            // The counter wraps here through clr, not inc.
                            cnt_clr      = 1'b1;
                            period_pulse = 1'b1;
                            if (reps_left == REP_W'(1)) begin
                                state_next = S_DONE;
                            end
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    busy       = 1'b1;
                    done       = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_IDLE;
                end

                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // State register and datapath. The command fields are latched on the
    // handshake. The prescaler restarts in CLEAR so that the first tick
    // lands pre cycles into RUN. reps_left only moves in finite mode, where
    // it never drops below 1 before the final period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            prescaler   <= '0;
            pre_reg     <= '0;
            cnt_max_val <= '0;
            reps_left   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cnt_max_val <= cmd_max;
                        pre_reg     <= cmd_pre;
                        reps_left   <= cmd_reps;
                    end
                end

                S_CLEAR: begin
                    prescaler <= '0;
                    if (abort) begin
                        reps_left <= '0;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        reps_left <= '0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
                        if (period_end && (reps_left != '0)) begin
                            reps_left <= reps_left - REP_W'(1);
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_counter_sequencer
//
// Directed testbench for counter_sequencer. A small behavioural counter
// closes the clr/inc/eq loop. A cycle-level model derives every expected
// output from the command's arithmetic: its offset from the handshake, the
// tick index and the period index. The compare process checks that model
// against the DUT on every cycle. The directed sequences also pin the model
// with hand-computed literal expectations at specific cycle offsets.
// ---------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int WIDTH = 8;
    localparam int PRE_W = 4;
    localparam int REP_W = 4;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_max;
    logic [PRE_W-1:0] cmd_pre;
    logic [REP_W-1:0] cmd_reps;
    logic             abort;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [WIDTH-1:0] cnt_max_val;
    logic             cnt_eq;
    logic             period_pulse;
    logic             done;
    logic             busy;
    logic [REP_W-1:0] reps_left;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;

    counter_sequencer #(
        .WIDTH(WIDTH),
        .PRE_W(PRE_W),
        .REP_W(REP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_max      (cmd_max),
        .cmd_pre      (cmd_pre),
        .cmd_reps     (cmd_reps),
        .abort        (abort),
        .cnt_clr      (cnt_clr),
        .cnt_inc      (cnt_inc),
        .cnt_max_val  (cnt_max_val),
        .cnt_eq       (cnt_eq),
        .period_pulse (period_pulse),
        .done         (done),
        .busy         (busy),
        .reps_left    (reps_left)
    );

    // Free-running clock plus a cycle index that advances on every rising edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural counter that stands in for the real counter block.
    logic [WIDTH-1:0] count;
    always @(posedge clk) begin
        if (cnt_clr) count <= '0;
        else if (cnt_inc) count <= count + 1'b1;
    end
    assign cnt_eq = (count == cnt_max_val);

    // Global safety net so that the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, need finished");
        $fatal(1, "[TB] watchdog");
    end

    // Shared comparison helper.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks_total++;
        if (actual == expected) checks_passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Move to the negedge sampling point of cycle c (c must lie in the future).
    task automatic go_to(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Move to just after the rising edge that starts cycle c, where inputs are driven.
    task automatic to_cycle_start(input int c);
        do begin @(posedge clk); #1; end while (cyc < c);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Present a command and wait, with a bound, for the handshake cycle.
    // Unless hold is set, cmd_valid drops again in the cycle after acceptance.
    task automatic applyStimulus(input int mx, input int pr, input int rp, input bit hold,
                                 output int t);
        bit got;
        got = 1'b0;
        t = cyc;
        cmd_max   = WIDTH'(mx);
        cmd_pre   = PRE_W'(pr);
        cmd_reps  = REP_W'(rp);
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                t = cyc;
            end
        end
        if (!got) checkOutput("handshake_timeout", 0, 1);
        if (!hold) begin
            next_edge();
            cmd_valid = 1'b0;
        end
    endtask

    // Reference model: expected outputs for the current cycle, derived from
    // the handshake cycle m_t and the command fields.
    bit               m_active = 1'b0;
    int               m_t, m_max, m_pre, m_reps;
    int               m_done_cycle = -1;
    logic [WIDTH-1:0] m_max_val = '0;
    logic [REP_W-1:0] m_reps_left = '0;

    always @(negedge clk) begin
        logic e_ready, e_clr, e_inc, e_pulse, e_done, e_busy;
        bit   p_end;
        int   d, k, j, p, per;
        logic [17:0] exp_vec, act_vec;
        if (cyc >= 1) begin
            e_ready = 0; e_clr = 0; e_inc = 0; e_pulse = 0; e_done = 0; e_busy = 0;
            p_end = 0; per = 0;
            d = cyc - m_t;
            if (rst) begin
                e_clr = 1;
            end else if (!m_active) begin
                e_ready = 1;
            end else begin
                e_busy = 1;
                if (cyc == m_done_cycle) begin
                    e_done = 1; e_clr = 1;
                end else if (abort || d == 1) begin
                    e_clr = 1;
                end else begin
                    k   = d - 2;
                    j   = k / (m_pre + 1);
                    p   = j % (m_max + 1);
                    per = j / (m_max + 1);
                    if ((k % (m_pre + 1)) == m_pre) begin
                        if (p == m_max) begin
                            p_end = 1; e_pulse = 1; e_clr = 1;
                        end else begin
                            e_inc = 1;
                        end
                    end
                end
            end

            exp_vec = {e_ready, e_clr, e_inc, e_pulse, e_done, e_busy, m_max_val, m_reps_left};
            act_vec = {cmd_ready, cnt_clr, cnt_inc, period_pulse, done, busy, cnt_max_val, reps_left};
            checks_total++;
            if (exp_vec === act_vec) checks_passed++;
            else $display("[TB] FAIL cycle_check cycle %0d: {ready,clr,inc,pulse,done,busy,max_val,reps_left} got %b expected %b",
                          cyc, act_vec, exp_vec);

            // Update what the registered outputs will hold in the next cycle.
            if (rst) begin
                m_active = 0; m_max_val = '0; m_reps_left = '0;
            end else if (!m_active) begin
                if (cmd_valid) begin
                    m_active = 1; m_t = cyc; m_done_cycle = -1;
                    m_max = int'(cmd_max); m_pre = int'(cmd_pre); m_reps = int'(cmd_reps);
                    m_max_val = cmd_max; m_reps_left = cmd_reps;
                end
            end else if (cyc == m_done_cycle) begin
                m_active = 0;
            end else if (abort) begin
                m_active = 0; m_reps_left = '0;
            end else if (p_end && m_reps != 0) begin
                m_reps_left = REP_W'(m_reps - per - 1);
                if (per == m_reps - 1) m_done_cycle = cyc + 1;
            end
        end
    end

    // Directed sequences with literal expectations.
    initial begin
        int t, t2, n;
        rst = 1; cmd_valid = 0; cmd_max = '0; cmd_pre = '0; cmd_reps = '0; abort = 0;

        // Reset state.
        go_to(1);
        checkOutput("rst_clr", cnt_clr, 1);
        checkOutput("rst_ready", cmd_ready, 0);
        to_cycle_start(3);
        rst = 0;
        @(negedge clk);
        checkOutput("idle_ready", cmd_ready, 1);
        checkOutput("idle_max_val", cnt_max_val, 0);
        next_edge();

        // Sequence 1: max=3 pre=0 reps=2.
        $display("[TB] sequence 1");
        applyStimulus(3, 0, 2, 0, t);
        go_to(t + 1);  checkOutput("s1_clr", cnt_clr, 1);
        go_to(t + 2);  checkOutput("s1_inc", cnt_inc, 1);
        go_to(t + 5);  checkOutput("s1_pulse1", period_pulse, 1);
        go_to(t + 9);  checkOutput("s1_pulse2", period_pulse, 1);
        go_to(t + 10); checkOutput("s1_done", done, 1);
        go_to(t + 11); checkOutput("s1_ready", cmd_ready, 1);
        next_edge();

        // Sequence 2: max=1 pre=2 reps=1, with abort held during DONE.
        $display("[TB] sequence 2");
        applyStimulus(1, 2, 1, 0, t);
        go_to(t + 3);  checkOutput("s2_no_inc", cnt_inc, 0);
        go_to(t + 4);  checkOutput("s2_inc", cnt_inc, 1);
        go_to(t + 7);  checkOutput("s2_pulse", period_pulse, 1);
        to_cycle_start(t + 8);
        abort = 1;
        @(negedge clk); checkOutput("s2_done_abort", done, 1);
        next_edge();
        abort = 0;

        // Sequence 3: max=0 pre=0 infinite, then abort.
        $display("[TB] sequence 3");
        applyStimulus(0, 0, 0, 0, t);
        go_to(t + 2);  checkOutput("s3_pulse", period_pulse, 1);
        checkOutput("s3_no_inc", cnt_inc, 0);
        to_cycle_start(t + 20);
        abort = 1;
        @(negedge clk); checkOutput("s3_abort_clr", cnt_clr, 1);
        checkOutput("s3_abort_pulse", period_pulse, 0);
        next_edge();
        abort = 0;
        @(negedge clk); checkOutput("s3_busy", busy, 0);
        checkOutput("s3_no_done", done, 0);
        next_edge();

        // Sequence 4: cmd_valid held high, second command latched fresh.
        $display("[TB] sequence 4");
        applyStimulus(1, 0, 2, 1, t);
        next_edge();
        cmd_max = 8'd2; cmd_pre = 4'd1; cmd_reps = 4'd1;
        t2 = -1;
        for (int i = 0; i < 50 && t2 < 0; i++) begin
            @(negedge clk);
            if (cmd_ready) t2 = cyc;
        end
        checkOutput("s4_second_accept", t2 - t, 7);
        next_edge();
        cmd_valid = 0;
        @(negedge clk); checkOutput("s4_max_val", cnt_max_val, 2);
        checkOutput("s4_reps_left", reps_left, 1);
        go_to(t2 + 8); checkOutput("s4_done", done, 1);
        next_edge();

        // Sequence 5: reset pulse mid-run.
        $display("[TB] sequence 5");
        applyStimulus(5, 1, 3, 0, t);
        to_cycle_start(t + 6);
        rst = 1;
        @(negedge clk); checkOutput("s5_rst_clr", cnt_clr, 1);
        checkOutput("s5_rst_busy", busy, 0);
        next_edge();
        rst = 0;
        @(negedge clk); checkOutput("s5_reps_left", reps_left, 0);
        checkOutput("s5_max_val", cnt_max_val, 0);
        checkOutput("s5_ready", cmd_ready, 1);
        next_edge();

        // Sequence 6: full-range count, max=255.
        $display("[TB] sequence 6");
        applyStimulus(255, 0, 1, 0, t);
        n = 0;
        for (int c = t + 2; c <= t + 256; c++) begin
            go_to(c);
            n += int'(cnt_inc);
        end
        checkOutput("s6_inc_count", n, 255);
        go_to(t + 257); checkOutput("s6_pulse", period_pulse, 1);
        go_to(t + 258); checkOutput("s6_done", done, 1);
        next_edge();

        // Sequence 7: abort in IDLE alongside a command, then abort in RUN.
        $display("[TB] sequence 7");
        abort = 1;
        applyStimulus(2, 0, 0, 0, t);
        abort = 0;
        @(negedge clk); checkOutput("s7_busy", busy, 1);
        to_cycle_start(t + 4);
        abort = 1;
        next_edge();
        abort = 0;
        @(negedge clk); checkOutput("s7_idle", busy, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
